// File: rtl/const_mult_shift_add_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : const_mult_shift_add_pipe_pkg
//  Description : Shared constants, mode encoding and helpers for the
//                pipelined shift-add constant multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package const_mult_shift_add_pipe_pkg;

  // Per-sample operating mode. The fourth code is folded onto bypass.
  typedef enum logic [1:0] {
    MODE_TRUNC  = 2'b00,
    MODE_ROUND  = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_RSVD   = 2'b11
  } cmul_mode_e;

  // 1/sqrt(2) ~= 2^-1 + 2^-3 + 2^-4 + 2^-6 + 2^-8 = 0.70703125
  localparam logic [15:0] INV_SQRT2_MASK_16 = 16'h015A;

  // Enabled edges from acceptance to the registered result.
  localparam int CMUL_LATENCY = 3;

  // Both upper codes pass the operand straight through.
  function automatic logic is_bypass(input logic [1:0] m);
    return (m == MODE_BYPASS) || (m == MODE_RSVD);
  endfunction

  // Round-half-up only applies to code 01.
  function automatic logic is_round(input logic [1:0] m);
    return (m == MODE_ROUND);
  endfunction

endpackage : const_mult_shift_add_pipe_pkg
`default_nettype wire

// File: rtl/const_mult_shift_add_pipe_partial_sum.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_partial_sum
//  Description : Combinational sum of (in << GUARD) >> k for every set bit k
//                of MASK inside the shift window [LO, HI]. Bits shifted below
//                the guard LSB are dropped (floor per term).
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_partial_sum #(
  parameter int                 WIDTH = 16,
  parameter int                 GUARD = 4,
  parameter int                 LO    = 0,
  parameter int                 HI    = 7,
  parameter logic [WIDTH-1:0]   MASK  = '0
) (
  input  logic [WIDTH-1:0]       data,
  output logic [WIDTH+GUARD+1:0] sum
);

  // Accumulator is two bits wider than the operand-with-guard; the full sum
  // of all terms is below 2*x, so neither partial nor total can overflow.
  localparam int AW = WIDTH + GUARD + 2;
  localparam int NT = HI - LO + 1;

  logic [AW-1:0] w_xe;
  logic [AW-1:0] w_terms [NT];
  logic [AW-1:0] w_acc;

  // Operand with guard bits appended below the LSB, zero-extended on top.
  assign w_xe = AW'(data) << GUARD;

  // One term per shift in the window; masked-off shifts contribute zero.
  for (genvar k = LO; k <= HI; k++) begin : g_term
    if (MASK[k]) begin : g_on
      assign w_terms[k-LO] = w_xe >> k;
    end else begin : g_off
      assign w_terms[k-LO] = '0;
    end
  end

  // Adder chain over the window terms.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < NT; i++) begin
      w_acc = w_acc + w_terms[i];
    end
  end

  assign sum = w_acc;

endmodule : shift_add_partial_sum
`default_nettype wire

// File: rtl/const_mult_shift_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : const_mult_shift_add_pipe
//  Description : Three-stage pipelined shift-add constant multiplier for
//                unsigned fixed-point data. Coefficient is a shift mask
//                (default 1/sqrt(2)); supports truncate, round-half-up and
//                bypass per sample, saturation to all-ones, valid tracking
//                and a global stall enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module const_mult_shift_add_pipe
  import const_mult_shift_add_pipe_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] SHIFT_MASK = WIDTH'(INV_SQRT2_MASK_16),
  parameter int               GUARD      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             sat
);

  localparam int AW      = WIDTH + GUARD + 2;
  localparam int HALF    = WIDTH / 2;
  localparam int RND_SH  = (GUARD > 0) ? (GUARD - 1) : 0;
  // Half an output LSB expressed in accumulator units; zero without guards.
  localparam logic [AW-1:0] ROUND_K = (GUARD > 0) ? (AW'(1) << RND_SH) : '0;

  // ---------------------------------------------------------------------
  // Stage 1: two half-window partial sums
  // ---------------------------------------------------------------------
  logic [AW-1:0]    w_p_lo;
  logic [AW-1:0]    w_p_hi;

  logic             r_s1_valid;
  logic [AW-1:0]    r_s1_p_lo;
  logic [AW-1:0]    r_s1_p_hi;
  logic [1:0]       r_s1_mode;
  logic [WIDTH-1:0] r_s1_byp;

  shift_add_partial_sum #(
    .WIDTH (WIDTH),
    .GUARD (GUARD),
    .LO    (0),
    .HI    (HALF - 1),
    .MASK  (SHIFT_MASK)
  ) u_psum_lo (
    .data (in_data),
    .sum  (w_p_lo)
  );

  shift_add_partial_sum #(
    .WIDTH (WIDTH),
    .GUARD (GUARD),
    .LO    (HALF),
    .HI    (WIDTH - 1),
    .MASK  (SHIFT_MASK)
  ) u_psum_hi (
    .data (in_data),
    .sum  (w_p_hi)
  );

  // Stage 1 register: capture partial sums, mode and the bypass operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_p_lo  <= '0;
      r_s1_p_hi  <= '0;
      r_s1_mode  <= MODE_TRUNC;
      r_s1_byp   <= '0;
    end else if (en) begin
      r_s1_valid <= in_valid;
      r_s1_p_lo  <= w_p_lo;
      r_s1_p_hi  <= w_p_hi;
      r_s1_mode  <= mode;
      r_s1_byp   <= in_data;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: combine halves and inject the rounding constant
  // ---------------------------------------------------------------------
  logic [AW-1:0]    w_s2_sum;

  logic             r_s2_valid;
  logic [AW-1:0]    r_s2_sum;
  logic [1:0]       r_s2_mode;
  logic [WIDTH-1:0] r_s2_byp;

  // Round-half-up is a single add of half an output LSB before the shift.
  always_comb begin
    w_s2_sum = r_s1_p_lo + r_s1_p_hi;
    if (is_round(r_s1_mode)) begin
      w_s2_sum = w_s2_sum + ROUND_K;
    end
  end

  // Stage 2 register: full-precision sum travels with its mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_mode  <= MODE_TRUNC;
      r_s2_byp   <= '0;
    end else if (en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sum   <= w_s2_sum;
      r_s2_mode  <= r_s1_mode;
      r_s2_byp   <= r_s1_byp;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: drop guard bits, saturate, select bypass
  // ---------------------------------------------------------------------
  logic [WIDTH+1:0] w_shr;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_sat;

  // Integer part of the accumulator; anything above WIDTH bits overflows.
  assign w_shr = r_s2_sum[AW-1:GUARD];
  assign w_ovf = |w_shr[WIDTH+1:WIDTH];

  // Result select: bypass wins, otherwise clip to all-ones on overflow.
  always_comb begin
    w_res = w_shr[WIDTH-1:0];
    w_sat = 1'b0;
    if (is_bypass(r_s2_mode)) begin
      w_res = r_s2_byp;
    end else if (w_ovf) begin
      w_res = '1;
      w_sat = 1'b1;
    end
  end

  // Output register: holds across stalls, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      out_valid <= r_s2_valid;
      out_data  <= w_res;
      sat       <= w_sat;
    end
  end

endmodule : const_mult_shift_add_pipe
`default_nettype wire

// File: tb/tb_const_mult_shift_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_const_mult_shift_add_pipe
//  Description : Directed self-checking bench. Three builds share stimulus:
//                default (1/sqrt(2), GUARD=4), GUARD=0, and SHIFT_MASK=0x0003.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_const_mult_shift_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  mode;

  logic        out_valid,  g0_out_valid,  m3_out_valid;
  logic [15:0] out_data,   g0_out_data,   m3_out_data;
  logic        sat,        g0_sat,        m3_sat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  const_mult_shift_add_pipe #(.WIDTH(16), .SHIFT_MASK(16'h015A), .GUARD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .out_valid(out_valid), .out_data(out_data), .sat(sat)
  );

  const_mult_shift_add_pipe #(.WIDTH(16), .SHIFT_MASK(16'h015A), .GUARD(0)) dut_g0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .out_valid(g0_out_valid), .out_data(g0_out_data), .sat(g0_sat)
  );

  const_mult_shift_add_pipe #(.WIDTH(16), .SHIFT_MASK(16'h0003), .GUARD(4)) dut_m3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .out_valid(m3_out_valid), .out_data(m3_out_data), .sat(m3_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample, then idle until its result sits on the outputs.
  task automatic run_one(input logic [15:0] d, input logic [1:0] m);
    in_valid = 1'b1; in_data = d; mode = m;
    step();
    in_valid = 1'b0; in_data = '0; mode = 2'b00;
    step();
    step();
  endtask

  // Stall stream tables, one entry per edge. in=0 means no sample; 15 is
  // junk offered while en=0. Samples k sit in the upper nibble (k<<12) so
  // results k*0x0B50 are all distinct. ex = sample index expected on the
  // outputs after that edge (0 = out_valid low).
  int en_t [13] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  int in_t [13] = '{1, 2, 3, 4, 15, 15, 5, 6, 7, 8, 0, 0, 0};
  int ex_t [13] = '{0, 0, 1, 2, 2, 2, 3, 4, 5, 6, 7, 8, 0};

  // Alternating bypass / truncate on 0x1234.
  logic [1:0]  alt_mode [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
  logic [15:0] alt_exp  [4] = '{16'h1234, 16'h0CDE, 16'h1234, 16'h0CDE};

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'b00;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data,  0);
    check("rst_sat",   sat,       0);

    // 0x8000 * 0.70703125 = 0x5A80; result present after the third edge only.
    in_valid = 1'b1; in_data = 16'h8000; mode = 2'b00;
    step();
    in_valid = 1'b0; in_data = '0;
    check("lat_e0_valid", out_valid, 0);
    step();
    check("lat_e1_valid", out_valid, 0);
    step();
    check("lat_e2_valid", out_valid, 1);
    check("lat_e2_data",  out_data,  16'h5A80);
    check("lat_e2_sat",   sat,       0);
    step();
    check("lat_e3_valid", out_valid, 0);

    // Full-scale input: truncate and round agree; GUARD=0 matches legacy chain.
    run_one(16'hFFFF, 2'b00);
    check("ffff_trunc",    out_data,    16'hB4FF);
    check("ffff_g0_trunc", g0_out_data, 16'hB4FB);
    check("ffff_g0_sat",   g0_sat,      0);
    run_one(16'hFFFF, 2'b01);
    check("ffff_round",    out_data,    16'hB4FF);
    // in=5: 3.5 in output units -> truncate 3, round 4.
    run_one(16'h0005, 2'b00);
    check("five_trunc",    out_data,    16'h0003);
    run_one(16'h0005, 2'b01);
    check("five_round",    out_data,    16'h0004);
    check("five_valid",    out_valid,   1);

    // x1.5 build: 0xC000*1.5 = 0x12000 clips; 0x4000*1.5 = 0x6000.
    run_one(16'hC000, 2'b00);
    check("m3_sat_valid",  m3_out_valid, 1);
    check("m3_sat_data",   m3_out_data,  16'hFFFF);
    check("m3_sat_flag",   m3_sat,       1);
    run_one(16'h4000, 2'b00);
    check("m3_ok_data",    m3_out_data,  16'h6000);
    check("m3_ok_flag",    m3_sat,       0);

    // Back-to-back stream with a 2-cycle stall in the middle.
    for (int i = 0; i < 13; i++) begin
      en       = (en_t[i] != 0);
      in_valid = (in_t[i] != 0);
      in_data  = 16'(in_t[i]) << 12;
      mode     = 2'b00;
      step();
      check($sformatf("strm%0d_valid", i), out_valid, (ex_t[i] != 0));
      if (ex_t[i] != 0) begin
        check($sformatf("strm%0d_data", i), out_data, 32'(ex_t[i]) * 32'h0B50);
      end
    end
    en = 1'b1; in_valid = 1'b0; in_data = '0;

    // Mode travels with each sample. Guard bits keep 0x1234 -> 0x0CDE
    // (the legacy GUARD=0 chain would give 0x0CDD).
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data  = 16'h1234;
      mode     = (i < 4) ? alt_mode[i] : 2'b00;
      step();
      if (i >= 2) begin
        check($sformatf("alt%0d_data", i - 2), out_data, alt_exp[i-2]);
        check($sformatf("alt%0d_sat", i - 2),  sat,      0);
      end
    end
    in_valid = 1'b0; in_data = '0;
    step();

    // Two samples in flight plus a third presented on the reset edge:
    // reset wins and nothing emerges afterwards.
    in_valid = 1'b1; in_data = 16'h8000; mode = 2'b00;
    step();
    in_data = 16'hFFFF;
    step();
    in_data = 16'h0005; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    check("rst2_valid", out_valid, 0);
    check("rst2_data",  out_data,  0);
    check("rst2_sat",   sat,       0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rst2_flush%0d", i), out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_const_mult_shift_add_pipe
`default_nettype wire
